// File: rtl/band_scan_selector.sv
// Registered CHANNELS-way selector with a manual mode and a dwell-timed scan mode.
// Optional channel masking in scan/manual is enabled by defining BAND_SCAN_SKIP_EN.
module band_scan_selector #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DWELL    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          ctrl,
    input  logic                      hold,
`ifdef BAND_SCAN_SKIP_EN
    input  logic [CHANNELS-1:0]       ch_mask,
`endif
    output logic [WIDTH-1:0]          out,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    output logic                      wrap
);

    localparam int              DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [SEL_W:0]  CH_LIM     = (SEL_W + 1)'(CHANNELS);

    typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;
    logic              out_valid_q, out_valid_d;
    logic              wrap_q, wrap_d;

    logic [SEL_W-1:0]  nxt_idx;
    logic [SEL_W-1:0]  first_idx;
    logic              nxt_wrap;
    logic              any_en;
    logic              cur_ok;
    logic              ctrl_ok;

    function automatic logic [WIDTH-1:0] chan_at(input logic [SEL_W-1:0] idx);
        chan_at = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) chan_at = in_bus[k*WIDTH +: WIDTH];
        end
    endfunction

`ifdef BAND_SCAN_SKIP_EN
    function automatic logic mask_at(input logic [SEL_W-1:0] idx);
        mask_at = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) mask_at = ch_mask[k];
        end
    endfunction

    // Searches run from the far end so the nearest enabled index is the last write.
    always_comb begin
        nxt_idx   = out_sel_q;
        first_idx = '0;
        for (int i = CHANNELS; i >= 1; i--) begin
            if (ch_mask[(int'(out_sel_q) + i) % CHANNELS])
                nxt_idx = SEL_W'((int'(out_sel_q) + i) % CHANNELS);
        end
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (ch_mask[k]) first_idx = SEL_W'(k);
        end
    end

    assign nxt_wrap  = (nxt_idx <= out_sel_q);
    assign any_en    = |ch_mask;
    assign cur_ok    = mask_at(out_sel_q);
    assign ctrl_ok   = ({1'b0, ctrl} < CH_LIM) && mask_at(ctrl);
    assign out_valid = out_valid_q && ((state_q == MANUAL) || cur_ok);
`else
    assign nxt_idx   = (out_sel_q == SEL_W'(CHANNELS - 1)) ? '0 : out_sel_q + SEL_W'(1);
    assign first_idx = '0;
    assign nxt_wrap  = (nxt_idx == '0);
    assign any_en    = 1'b1;
    assign cur_ok    = 1'b1;
    assign ctrl_ok   = ({1'b0, ctrl} < CH_LIM);
    assign out_valid = out_valid_q;
`endif

    always_comb begin
        state_d     = state_q;
        dwell_d     = dwell_q;
        out_d       = out_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        wrap_d      = 1'b0;
        if (!hold) begin
            if (!mode) begin
                state_d = MANUAL;
                dwell_d = '0;
                if (ctrl_ok) begin
                    out_d       = chan_at(ctrl);
                    out_sel_d   = ctrl;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (state_q == MANUAL) begin
                // Entry edge shows the first channel with dwell 0, so it counts as visible cycle one.
                state_d = SCAN;
                dwell_d = '0;
                if (any_en) begin
                    out_d       = chan_at(first_idx);
                    out_sel_d   = first_idx;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (!any_en) begin
                out_valid_d = 1'b0;
            end else if (!cur_ok || (dwell_q == DWELL_LAST)) begin
                dwell_d     = '0;
                out_d       = chan_at(nxt_idx);
                out_sel_d   = nxt_idx;
                out_valid_d = 1'b1;
                wrap_d      = nxt_wrap;
            end else begin
                dwell_d     = dwell_q + DW_W'(1);
                out_d       = chan_at(out_sel_q);
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MANUAL;
            dwell_q     <= '0;
            out_q       <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            out_q       <= out_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            wrap_q      <= wrap_d;
        end
    end

    assign out     = out_q;
    assign out_sel = out_sel_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_band_scan_selector.sv
// Directed bench for band_scan_selector: two instances (8ch/DWELL=4 and 6ch/DWELL=1)
// share control inputs; manual vectors are table-driven, scan/hold are hand sequences.
module tb_band_scan_selector;

    logic        clk = 1'b0;
    logic        rst, mode, hold;
    logic [2:0]  ctrl;
    logic [31:0] in_bus0;
    logic [23:0] in_bus1;
    logic [3:0]  out0, out1;
    logic [2:0]  out_sel0, out_sel1;
    logic        out_valid0, out_valid1, wrap0, wrap1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    band_scan_selector #(.WIDTH(4), .CHANNELS(8), .SEL_W(3), .DWELL(4)) u0 (
        .clk(clk), .rst(rst), .in_bus(in_bus0), .mode(mode), .ctrl(ctrl), .hold(hold),
`ifdef BAND_SCAN_SKIP_EN
        .ch_mask(8'hFF),
`endif
        .out(out0), .out_sel(out_sel0), .out_valid(out_valid0), .wrap(wrap0)
    );

    band_scan_selector #(.WIDTH(4), .CHANNELS(6), .SEL_W(3), .DWELL(1)) u1 (
        .clk(clk), .rst(rst), .in_bus(in_bus1), .mode(mode), .ctrl(ctrl), .hold(hold),
`ifdef BAND_SCAN_SKIP_EN
        .ch_mask(6'h3F),
`endif
        .out(out1), .out_sel(out_sel1), .out_valid(out_valid1), .wrap(wrap1)
    );

    typedef struct {
        logic       rst;
        logic       mode;
        logic       hold;
        logic [2:0] ctrl;
        logic [3:0] o0;
        logic [2:0] s0;
        logic       v0;
        logic [3:0] o1;
        logic [2:0] s1;
        logic       v1;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input logic [3:0] o0, input logic [2:0] s0, input logic v0, input logic w0,
                           input logic [3:0] o1, input logic [2:0] s1, input logic v1, input logic w1);
        chk("out0", 32'(out0), 32'(o0));
        chk("out_sel0", 32'(out_sel0), 32'(s0));
        chk("out_valid0", 32'(out_valid0), 32'(v0));
        chk("wrap0", 32'(wrap0), 32'(w0));
        chk("out1", 32'(out1), 32'(o1));
        chk("out_sel1", 32'(out_sel1), 32'(s1));
        chk("out_valid1", 32'(out_valid1), 32'(v1));
        chk("wrap1", 32'(wrap1), 32'(w1));
    endtask

    // Channel k of u0 carries k+1, channel k of u1 carries k+9.
    task automatic set_pattern();
        in_bus0 = {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        in_bus1 = {4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9};
    endtask

    task automatic randomize_inputs();
        logic [31:0] r;
        r       = $urandom;
        in_bus0 = $urandom;
        in_bus1 = r[23:0];
        r       = $urandom;
        ctrl    = r[2:0];
    endtask

    // Scan position t counts unheld edges since scan entry (t=0 is the entry edge).
    task automatic scan_chk(input int t);
        int s0, s1;
        s0 = (t / 4) % 8;
        s1 = t % 6;
        chk_all(4'(s0 + 1), 3'(s0), 1'b1, (t > 0) && (t % 32 == 0),
                4'(s1 + 9), 3'(s1), 1'b1, (t > 0) && (t % 6 == 0));
    endtask

    initial begin
        logic [31:0] r;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 3'd5, 4'd6, 3'd5, 1'b1, 4'd14, 3'd5, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 3'd2, 4'd3, 3'd2, 1'b1, 4'd11, 3'd2, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 3'd7, 4'd8, 3'd7, 1'b1, 4'd11, 3'd2, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 3'd0, 4'd8, 3'd7, 1'b1, 4'd11, 3'd2, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 3'd0, 4'd1, 3'd0, 1'b1, 4'd9,  3'd0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 3'd4, 4'd0, 3'd0, 1'b0, 4'd0,  3'd0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 3'd3, 4'd4, 3'd3, 1'b1, 4'd12, 3'd3, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 3'd1, 4'd2, 3'd1, 1'b1, 4'd10, 3'd1, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 3'd6, 4'd7, 3'd6, 1'b1, 4'd10, 3'd1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 3'd4, 4'd5, 3'd4, 1'b1, 4'd13, 3'd4, 1'b1};

        // Reset overrides mode and hold while inputs churn.
        rst  = 1'b1;
        mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            r    = $urandom;
            hold = r[0];
            step();
            chk_all(4'd0, 3'd0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0);
        end

        // Full scan from reset release, past one complete u0 cycle.
        rst  = 1'b0;
        hold = 1'b0;
        set_pattern();
        for (int t = 0; t <= 40; t++) begin
            step();
            scan_chk(t);
        end

        // Reset mid-scan abandons the position; scan then restarts at channel 0.
        rst = 1'b1;
        step();
        chk_all(4'd0, 3'd0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int t = 0; t <= 14; t++) begin
            step();
            scan_chk(t);
        end

        // Hold at u0 out_sel=3, dwell=2: everything frozen, inputs ignored.
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            randomize_inputs();
            r    = $urandom;
            mode = r[0];
            step();
            chk_all(4'd4, 3'd3, 1'b1, 1'b0, 4'd11, 3'd2, 1'b1, 1'b0);
        end
        hold = 1'b0;
        mode = 1'b1;
        set_pattern();
        for (int t = 15; t <= 20; t++) begin
            step();
            scan_chk(t);
        end

        // Manual vectors, starting with the SCAN -> MANUAL exit.
        for (int i = 0; i < 10; i++) begin
            rst  = vecs[i].rst;
            mode = vecs[i].mode;
            hold = vecs[i].hold;
            ctrl = vecs[i].ctrl;
            step();
            chk_all(vecs[i].o0, vecs[i].s0, vecs[i].v0, 1'b0,
                    vecs[i].o1, vecs[i].s1, vecs[i].v1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
